// File: rtl/lcd_feed_pkg.sv
// Shared definitions for the LCD pixel feeder: black pixel value, default
// pixel width and the frame-alignment FSM encoding.
package lcd_feed_pkg;

    localparam int DATA_W_DEF = 16;

    localparam logic [DATA_W_DEF-1:0] BLACK = 16'h0000;

    typedef enum logic [1:0] {
        S_WAIT_VS = 2'd0,
        S_ALIGN   = 2'd1,
        S_RUN     = 2'd2
    } feed_state_t;

endpackage

// File: rtl/lcd_sof_fifo.sv
// Pixel FIFO storing {sof, data}; sof is readable combinationally at the head,
// data is read synchronously on pop so the array maps onto block RAM.
module lcd_sof_fifo
    import lcd_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              wr_sof,
    output logic              head_sof,
    output logic [DATA_W-1:0] rd_data,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [DEPTH-1:0]  sof_mem;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;

    // Storage is never reset: entries written before a reset become invalid
    // simply because the pointers and count return to zero.
    always_ff @(posedge clk) begin
        if (push) begin
            data_mem[wr_ptr] <= wr_data;
            sof_mem[wr_ptr]  <= wr_sof;
        end
        if (pop) begin
            rd_data <= data_mem[rd_ptr];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_sof = sof_mem[rd_ptr];
    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/lcd_pixel_feeder.sv
// Frame-aligned pixel feeder: buffers scaler pixels, realigns to the start of
// frame on every vsync rise and substitutes black on underrun.
module lcd_pixel_feeder
    import lcd_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 1024,
    parameter int AW     = 10
) (
    input  logic              lcd_pclk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sof,
    input  logic              lcd_vs,
    input  logic              data_req,
    output logic [DATA_W-1:0] pixel_data,
    output logic              underrun,
    output logic [AW:0]       fill_level
);

    feed_state_t       state, next_state;
    logic              vs_d;
    logic              vs_rise;
    logic              first_pend, first_pend_next;
    logic              served_d;
    logic              push, pop, serve, under_set;
    logic              head_sof, full, empty;
    logic [DATA_W-1:0] rd_data;

    lcd_sof_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_fifo (
        .clk      (lcd_pclk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .wr_data  (in_data),
        .wr_sof   (in_sof),
        .head_sof (head_sof),
        .rd_data  (rd_data),
        .count    (fill_level),
        .full     (full),
        .empty    (empty)
    );

    assign in_ready = rst_n & ~full;
    assign push     = in_valid & in_ready;
    assign vs_rise  = lcd_vs & ~vs_d;

    always_ff @(posedge lcd_pclk) begin
        if (!rst_n) begin
            state      <= S_WAIT_VS;
            first_pend <= 1'b0;
            vs_d       <= 1'b0;
            served_d   <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            state      <= next_state;
            first_pend <= first_pend_next;
            vs_d       <= lcd_vs;
            served_d   <= serve;
            if (under_set)    underrun <= 1'b1;
            else if (vs_rise) underrun <= 1'b0;
        end
    end

    // A next-frame sof at the head is only consumed as the first pixel after
    // an alignment, so a short frame underruns instead of spilling over.
    always_comb begin
        next_state      = state;
        first_pend_next = first_pend;
        pop             = 1'b0;
        serve           = 1'b0;
        under_set       = 1'b0;
        case (state)
            S_WAIT_VS: begin
                if (vs_rise) next_state = S_ALIGN;
            end
            S_ALIGN: begin
                under_set = data_req;
                if (!empty) begin
                    if (head_sof) begin
                        next_state      = S_RUN;
                        first_pend_next = 1'b1;
                    end else begin
                        pop = 1'b1;
                    end
                end
            end
            S_RUN: begin
                serve     = data_req & ~empty & (first_pend | ~head_sof);
                pop       = serve;
                under_set = data_req & ~serve;
                if (serve)   first_pend_next = 1'b0;
                if (vs_rise) next_state      = S_ALIGN;
            end
            default: next_state = S_WAIT_VS;
        endcase
    end

    assign pixel_data = served_d ? rd_data : DATA_W'(BLACK);

endmodule

// File: tb/tb_lcd_pixel_feeder.sv
// Self-checking bench for lcd_pixel_feeder: directed frame scenarios plus
// randomized traffic against a queue-based reference model.
module tb_lcd_pixel_feeder;
    import lcd_feed_pkg::*;

    localparam int DEPTH = 1024;

    localparam int M_WAIT  = 0;
    localparam int M_ALIGN = 1;
    localparam int M_RUN   = 2;

    typedef struct packed {
        logic        sof;
        logic [15:0] data;
    } ent_t;

    logic        lcd_pclk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sof;
    logic        lcd_vs;
    logic        data_req;
    logic [15:0] pixel_data;
    logic        underrun;
    logic [10:0] fill_level;

    ent_t        q[$];
    int          mode;
    bit          m_first;
    bit          m_vs_prev;
    bit          m_under;
    logic [15:0] m_pix;

    int tests_run;
    int tests_failed;

    lcd_pixel_feeder #(
        .DATA_W (16),
        .DEPTH  (DEPTH),
        .AW     (10)
    ) dut (
        .lcd_pclk   (lcd_pclk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sof     (in_sof),
        .lcd_vs     (lcd_vs),
        .data_req   (data_req),
        .pixel_data (pixel_data),
        .underrun   (underrun),
        .fill_level (fill_level)
    );

    initial lcd_pclk = 1'b0;
    always #5 lcd_pclk = ~lcd_pclk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock of the feeder described in terms of a frame queue.
    function automatic void modelStep(input bit rst, input bit v, input bit s,
                                      input logic [15:0] d, input bit vs, input bit req);
        bit   vs_rise, take, drop, miss;
        ent_t e;
        if (!rst) begin
            q.delete();
            mode      = M_WAIT;
            m_first   = 0;
            m_vs_prev = 0;
            m_under   = 0;
            m_pix     = 16'h0000;
            return;
        end
        vs_rise = vs && !m_vs_prev;
        take    = v && (q.size() != DEPTH);
        drop    = 0;
        miss    = 0;
        m_pix   = 16'h0000;
        if (mode == M_WAIT) begin
            if (vs_rise) mode = M_ALIGN;
        end else if (mode == M_ALIGN) begin
            miss = req;
            if (q.size() > 0) begin
                if (q[0].sof) begin
                    mode    = M_RUN;
                    m_first = 1;
                end else begin
                    drop = 1;
                end
            end
        end else begin
            if (req && q.size() > 0 && (m_first || !q[0].sof)) begin
                m_pix   = q[0].data;
                drop    = 1;
                m_first = 0;
            end else if (req) begin
                miss = 1;
            end
            if (vs_rise) mode = M_ALIGN;
        end
        if (drop) void'(q.pop_front());
        if (take) begin
            e.sof  = s;
            e.data = d;
            q.push_back(e);
        end
        if (miss)         m_under = 1;
        else if (vs_rise) m_under = 0;
        m_vs_prev = vs;
    endfunction

    task automatic applyStimulus(input bit rst, input bit v, input bit s,
                                 input logic [15:0] d, input bit vs, input bit req);
        rst_n    = rst;
        in_valid = v;
        in_sof   = s;
        in_data  = d;
        lcd_vs   = vs;
        data_req = req;
        #1;
        checkOutput("in_ready", in_ready, (rst && q.size() != DEPTH));
        modelStep(rst, v, s, d, vs, req);
        @(posedge lcd_pclk);
        #1;
        checkOutput("pixel_data", pixel_data, m_pix);
        checkOutput("underrun", underrun, m_under);
        checkOutput("fill_level", fill_level, q.size());
    endtask

    task automatic idle(input int n, input bit vs);
        for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 16'h0, vs, 0);
    endtask

    task automatic pushPx(input bit s, input logic [15:0] d);
        applyStimulus(1, 1, s, d, 0, 0);
    endtask

    task automatic reqPx();
        applyStimulus(1, 0, 0, 16'h0, 0, 1);
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 16'h0, 0, 0);
    endtask

    initial begin
        logic [15:0] t1_vals [4];
        tests_run    = 0;
        tests_failed = 0;
        t1_vals[0] = 16'hF800;
        t1_vals[1] = 16'h07E0;
        t1_vals[2] = 16'h001F;
        t1_vals[3] = 16'hFFFF;

        // Basic frame: four pixels served in order after one vsync.
        resetCycles(2);
        checkOutput("rst_fill", fill_level, 0);
        checkOutput("rst_pixel", pixel_data, 0);
        checkOutput("rst_underrun", underrun, 0);
        for (int i = 0; i < 4; i++) pushPx(i == 0, t1_vals[i]);
        idle(1, 1);
        idle(1, 0);
        for (int i = 0; i < 4; i++) begin
            reqPx();
            checkOutput("t1_pixel", pixel_data, t1_vals[i]);
        end
        checkOutput("t1_underrun", underrun, 0);

        // Stale entries are discarded before the sof pixel.
        resetCycles(1);
        pushPx(0, 16'hAAA1);
        pushPx(0, 16'hAAA2);
        pushPx(0, 16'hAAA3);
        pushPx(1, 16'h1234);
        pushPx(0, 16'h5678);
        idle(1, 1);
        idle(4, 0);
        checkOutput("t2_fill", fill_level, 2);
        reqPx();
        checkOutput("t2_first", pixel_data, 16'h1234);

        // Underrun on an empty FIFO is sticky until the next vsync rise.
        reqPx();
        checkOutput("t3_last", pixel_data, 16'h5678);
        reqPx();
        checkOutput("t3_black", pixel_data, 16'h0000);
        checkOutput("t3_under_set", underrun, 1);
        idle(3, 0);
        checkOutput("t3_under_hold", underrun, 1);
        idle(1, 1);
        checkOutput("t3_under_clr", underrun, 0);
        idle(1, 0);

        // Full FIFO refuses a push even in a cycle that pops.
        resetCycles(1);
        for (int i = 0; i < DEPTH; i++) applyStimulus(1, 1, i == 0, 16'(i), i == 0, 0);
        checkOutput("t4_full_fill", fill_level, 1024);
        checkOutput("t4_full_ready", in_ready, 0);
        applyStimulus(1, 1, 0, 16'hBEEF, 0, 1);
        checkOutput("t4_pop_fill", fill_level, 1023);
        checkOutput("t4_pop_pixel", pixel_data, 16'h0000);
        checkOutput("t4_ready_back", in_ready, 1);
        reqPx();
        checkOutput("t4_second", pixel_data, 16'h0001);

        // Short frame: next frame's sof is held back for the next alignment.
        resetCycles(1);
        pushPx(1, 16'hA001);
        pushPx(0, 16'hB002);
        pushPx(1, 16'hC003);
        idle(1, 1);
        idle(1, 0);
        reqPx();
        checkOutput("t5_a", pixel_data, 16'hA001);
        reqPx();
        checkOutput("t5_b", pixel_data, 16'hB002);
        reqPx();
        checkOutput("t5_black", pixel_data, 16'h0000);
        checkOutput("t5_under", underrun, 1);
        checkOutput("t5_kept", fill_level, 1);
        idle(1, 1);
        idle(1, 0);
        reqPx();
        checkOutput("t5_c", pixel_data, 16'hC003);

        // Mid-frame reset flushes the FIFO and waits for a new vsync.
        resetCycles(1);
        for (int i = 0; i < 500; i++) applyStimulus(1, 1, i == 0, 16'(i + 7), i == 0, 0);
        reqPx();
        checkOutput("t6_fill_pre", fill_level, 499);
        pushPx(0, 16'h4444);
        checkOutput("t6_fill_500", fill_level, 500);
        applyStimulus(0, 1, 0, 16'h1111, 0, 1);
        checkOutput("t6_fill", fill_level, 0);
        checkOutput("t6_state", 32'(dut.state), 32'(S_WAIT_VS));
        checkOutput("t6_pixel", pixel_data, 0);
        for (int i = 0; i < 3; i++) applyStimulus(1, 1, i == 0, 16'h2220 + 16'(i), 0, 1);
        checkOutput("t6_nopop", fill_level, 3);
        checkOutput("t6_black", pixel_data, 0);

        // Random traffic with periodic vsync and occasional resets.
        for (int cyc = 0; cyc < 3000; cyc++) begin
            applyStimulus($urandom_range(0, 599) != 0,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 7) == 0,
                          16'($urandom),
                          (cyc % 150) < 2,
                          $urandom_range(0, 1) == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
